// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, commits to
// an internal word array and returns a single-cycle response pulse.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WaitInit  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic            accept;
  logic            req_err;
  logic            commit;
  logic            c_we;
  logic            c_err;
  logic [31:0]     c_addr;
  logic [31:0]     c_wdata;
  logic [3:0]      c_be;
  logic [IdxW-1:0] c_idx;

  assign accept = (state_q == StIdle) && req_valid;

  always_comb begin
    req_err = (req_addr[1:0] != 2'b00) || ((req_addr - BASE_ADDR) >= SpanBytes);
  end

  // With no wait states the commit happens on the acceptance edge itself, so the
  // live request feeds the array; otherwise the latched copy does.
  always_comb begin
    commit  = 1'b0;
    c_we    = we_q;
    c_err   = err_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (WAIT_CYCLES == 0) begin
      commit  = accept;
      c_we    = req_we;
      c_err   = req_err;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      commit = (state_q == StWait) && (cnt_q == 4'd0);
    end
    c_idx = IdxW'((c_addr - BASE_ADDR) >> 2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            err_q   <= req_err;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= WaitInit;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      rsp_valid_q <= commit;
      if (commit) begin
        rsp_err_q   <= c_err;
        rsp_rdata_q <= (!c_err && !c_we) ? mem_q[c_idx] : 32'd0;
      end else if (state_q == StResp) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= 32'd0;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && !c_err && c_we) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) begin
          mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random traffic against a word-array model,
// plus a zero-wait-state instance for back-to-back timing.
module tb_dmem_responder;

  localparam int unsigned Wait  = 2;
  localparam int unsigned Words = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        v0 = 1'b0, we0 = 1'b0;
  logic [31:0] a0 = '0, wd0 = '0;
  logic [3:0]  be0 = '0;
  logic        rdy0, rv0, er0, bz0;
  logic [31:0] rd0;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [Words];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(Words), .WAIT_CYCLES(Wait), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(Words), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(a0), .req_wdata(wd0), .req_be(be0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(er0), .busy(bz0)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= Words * 4);
  endfunction

  // Issue one request on the waited instance; called and returns at a falling edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output logic er);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk);
    #1;
    // Scramble the request lines: only the acceptance edge may sample them.
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_be = 4'($urandom);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      chk("wait_busy", {31'd0, busy}, 32'd1);
      chk("wait_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(Wait + 1));
    chk("resp_ready", {31'd0, req_ready}, 32'd0);
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic ref_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] exp_rd, rd;
    logic        exp_er, er;
    int          idx;
    exp_er = exp_err(addr);
    exp_rd = 32'd0;
    idx    = int'(addr / 4);
    if (!exp_er) begin
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = model[idx];
      end
    end
    txn(we, addr, wd, be, rd, er);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] last_addr;
    int          acc, pulses;

    // Reset values
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    chk("rst0_ready", {31'd0, rdy0}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Give every word a known value
    for (int i = 0; i < Words; i++) ref_txn("init", 1'b1, 32'(i * 4), $urandom, 4'hF);

    // Store then load
    ref_txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("ld10_data", rd, 32'hDEAD_BEEF);
    chk("ld10_err", {31'd0, er}, 32'd0);

    // Byte enables
    ref_txn("pre20", 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    ref_txn("be20", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er);
    chk("be20_data", rd, 32'h11BB_33DD);
    ref_txn("be0", 1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000);
    ref_txn("be0_rb", 1'b0, 32'h24, 32'h0, 4'h0);

    // Errors and boundaries
    ref_txn("mis402", 1'b0, 32'h402, 32'h0, 4'h0);
    ref_txn("oor400", 1'b1, 32'h400, 32'h1234_5678, 4'hF);
    ref_txn("rb_w0", 1'b0, 32'h0, 32'h0, 4'h0);
    ref_txn("rb_w255", 1'b0, 32'h3FC, 32'h0, 4'h0);
    ref_txn("mis_st", 1'b1, 32'h11, 32'h5555_5555, 4'hF);
    ref_txn("rb_w4", 1'b0, 32'h10, 32'h0, 4'h0);
    ref_txn("oor_hi", 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, Words - 1)) << 2;
      else if (sel < 9) a = 32'($urandom_range(0, 1100));
      else              a = $urandom;
      ref_txn("rand", 1'($urandom), a, $urandom, 4'($urandom));
    end

    // Continuous request stream: one acceptance every Wait+2 cycles
    acc = 0; pulses = 0; last_addr = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
    for (int c = 0; c < 24; c++) begin
      chk("hs_ready", {31'd0, req_ready}, {31'd0, c % 4 == 0});
      chk("hs_busy", {31'd0, busy}, {31'd0, c % 4 != 0});
      chk("hs_valid", {31'd0, rsp_valid}, {31'd0, c % 4 == 3});
      if (rsp_valid) begin
        pulses++;
        chk("hs_rdata", rsp_rdata, model[last_addr / 4]);
      end
      if (req_ready) begin
        acc++;
        last_addr = req_addr;
      end
      @(negedge clk);
      req_addr = (acc % 2 == 1) ? 32'h4 : 32'h0;
    end
    req_valid = 1'b0;
    chk("hs_accepts", 32'(acc), 32'd6);
    chk("hs_pulses", 32'(pulses), 32'(acc));

    // Zero wait states: response at T+1, next acceptance at T+2
    v0 = 1'b1; we0 = 1'b1; a0 = 32'hC; wd0 = 32'h0BAD_F00D; be0 = 4'hF;
    @(posedge clk);
    #1;
    we0 = 1'b0; wd0 = 32'h0;
    @(negedge clk);
    chk("w0_st_valid", {31'd0, rv0}, 32'd1);
    chk("w0_st_ready", {31'd0, rdy0}, 32'd0);
    chk("w0_st_busy", {31'd0, bz0}, 32'd1);
    chk("w0_st_rdata", rd0, 32'd0);
    @(negedge clk);
    chk("w0_idle_ready", {31'd0, rdy0}, 32'd1);
    chk("w0_idle_valid", {31'd0, rv0}, 32'd0);
    @(negedge clk);
    v0 = 1'b0;
    chk("w0_ld_valid", {31'd0, rv0}, 32'd1);
    chk("w0_ld_rdata", rd0, 32'h0BAD_F00D);
    chk("w0_ld_err", {31'd0, er0}, 32'd0);

    // Reset while waiting aborts the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFE_F00D;
    req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    chk("abort_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    ref_txn("abort_rb", 1'b0, 32'h8, 32'h0, 4'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
